serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled on the clk rising edge.
REQ-005 The block SHALL have port a  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-006 The block SHALL have port b  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-007 The block SHALL have port cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 The block SHALL have port busy  output  1  addition in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking that sum/cout/ovf are valid.
REQ-010 The block SHALL have port sum  output  WIDTH  result, equal to (a+b+cin) mod 2^WIDTH.
REQ-011 The block SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-012 The block SHALL have port ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The block SHALL compute one result bit per clock, LSB first, using a single 1-bit full-adder stage (s = x^y^c; c' = xy|xc|yc) fed from operand shift registers and a registered carry.
REQ-014 The FSM SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1).
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL load a, b into shift registers, load cin into the carry flop, clear the bit counter, clear sum, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL hold all registers and keep sum/cout/ovf at their last values.
REQ-017 On each RUN edge, the block SHALL shift the full-adder sum bit into sum at bit WIDTH-1 (sum shifts right), shift both operand registers right by one, store the full-adder carry into the carry flop, and increment the counter.
REQ-018 On the RUN edge where counter == WIDTH-1, the block SHALL complete the final shift, latch cout = final carry and ovf = (carry entering that bit) XOR (final carry), return to IDLE, and assert done for exactly the following cycle.
REQ-019 Latency: if start is accepted at edge k, busy SHALL be 1 after edges k..k+WIDTH-1, and done SHALL be 1 only in the cycle after edge k+WIDTH, with busy=0 in that cycle.
REQ-020 start while busy=1 SHALL be ignored; operands and results SHALL be unaffected, and no request SHALL be queued.
REQ-021 start=1 in the cycle where done=1 SHALL be accepted (back-to-back throughput of one result per WIDTH+1 cycles).
REQ-022 During RUN, sum SHALL show partial shifted contents, and cout/ovf SHALL hold their previous values; only values in the done cycle and after are defined results.
REQ-023 Results SHALL remain stable in IDLE until the next accepted start.
REQ-024 Carry arithmetic SHALL be exact for all inputs, including a=b=2^WIDTH-1 with cin=1.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL force state=IDLE and busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry flop and operand registers.
REQ-026 If reset is asserted mid-RUN, the in-flight addition SHALL be abandoned, and no done pulse SHALL follow reset release.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 Scenario: a=0x00, b=0x00, cin=0 -> done 8 cycles after the start edge, sum=0x00, cout=0, ovf=0.
REQ-029 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-030 Scenario: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0; a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
REQ-031 Scenario: start with a=0x12, b=0x34, then a second start with a=0xFF on the 3rd busy cycle -> sum=0x46, cout=0, and exactly one done pulse.
REQ-032 Scenario: rst_n=0 after 4 RUN cycles -> busy=0 and sum=0 immediately, and no done pulse; start after release with 0x05+0x03 -> sum=0x08.
REQ-033 Scenario: 1000 back-to-back random (a, b, cin) with start held high -> each done pulse matches a reference a+b+cin for {cout, sum} and ovf, with done spaced exactly 9 cycles apart.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage, LSB first, WIDTH clocks per result.
// Result registers hold their values in IDLE until the next accepted start.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c;
    logic             w_last;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_cnt   <= '0;
                r_sum   <= '0;
            end else if (r_state == StRun) begin
                r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_c;
                r_cnt   <= r_cnt + 1'b1;
                // r_carry here is the carry into the MSB stage.
                if (w_last) begin
                    r_cout <= w_c;
                    r_ovf  <= r_carry ^ w_c;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == StRun);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
